vta_mem_req_sequencer: RTL and testbench
========================================

# vta_mem_req_sequencer

Command sequencer that sits directly upstream of the DPI memory model and drives its `dpi_*` request, write and read ports. It accepts one read or write burst command at a time from the accelerator load/store units. For a write, it streams the write beats out; for a read, it collects the returned beats into a small FIFO with backpressure. It compensates for the model's one-cycle registered read outputs, so no returned beat is ever lost.

## Interface
- `LEN_BITS`, 32, width of the burst length field; length encodes beats−1.
- `ADDR_BITS`, 64, byte address width.
- `DATA_BITS`, 64, beat width.
- `RD_FIFO_DEPTH`, 4, read FIFO entries; power of two, ≥2.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_opcode` in 1: 0 read, 1 write.
- `cmd_addr` in `ADDR_BITS`: start address.
- `cmd_len` in `LEN_BITS`: beats−1.
- `wr_valid` in 1, `wr_ready` out 1, `wr_bits` in `DATA_BITS`: write data stream.
- `rd_valid` out 1, `rd_ready` in 1, `rd_bits` out `DATA_BITS`: read data stream, FIFO head.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.
- `err` out 1: sticky protocol error.
- `dpi_req_valid` out 1, `dpi_req_opcode` out 1, `dpi_req_len` out `LEN_BITS`, `dpi_req_addr` out `ADDR_BITS`: to the model.
- `dpi_wr_valid` out 1, `dpi_wr_bits` out `DATA_BITS`: to the model.
- `dpi_rd_valid` in 1, `dpi_rd_bits` in `DATA_BITS`, `dpi_rd_ready` out 1: from/to the model.

## Operation
- FSM states: IDLE, REQ, WRITE, READ. A beat counter `cnt` (`LEN_BITS`) is compared to the latched length.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`: latch opcode/addr/len, clear `cnt`, go to REQ.
- REQ:
  - `dpi_req_valid`=1 for exactly one cycle, with the latched opcode/len/addr.
  - Next state: WRITE if opcode=1, else READ.
- WRITE:
  - `wr_ready`=1.
  - Each accepted beat is registered onto `dpi_wr_valid`/`dpi_wr_bits` next cycle; `dpi_wr_valid`=0 on other cycles.
  - When the beat with `cnt==len` is accepted, go to IDLE; otherwise `cnt`+1.
- READ:
  - `dpi_rd_ready` = (state==READ) && (free entries ≥2). The one-entry slack absorbs the beat already in flight from the registered model output.
  - Each `dpi_rd_valid` beat is pushed to the FIFO and `cnt`+1.
  - After the beat with `cnt==len`, go to IDLE. The FIFO may still hold data; the next command may start while it drains.
- FIFO:
  - Circular buffer; read and write pointers carry one extra wrap bit.
  - Full when pointers are equal except for the wrap bit; empty when fully equal.
  - Push and pop in the same cycle while full or empty is legal; occupancy is unchanged when both occur.
- Errors (set `err`, sticky until reset; the beat is dropped):
  - `dpi_rd_valid` while the FIFO is full.
  - `dpi_rd_valid` outside READ.
- `dpi_req_len` carries the beats−1 value unchanged.

## Timing
- Reset values (async on `reset`=0):
  - FSM IDLE, FIFO empty, `cnt`=0, `err`=0.
  - All `dpi_*` outputs 0; `wr_ready`=0, `rd_valid`=0, `busy`=0.
  - `cmd_ready` gated to 0 while `reset`=0.
- Reset mid-burst: everything returns to the values above immediately. Partially delivered beats are discarded; no further `dpi_*` activity occurs.
- Write latency: command handshake at cycle 0 → `dpi_req_valid` at cycle 1 → first `wr_ready` at cycle 2 → that beat appears on `dpi_wr_valid` at cycle 3.
- Read latency: `dpi_rd_valid` at cycle t → `rd_valid` at t+1 if the FIFO was empty (registered head).
- `cmd_ready` reasserts the cycle after the last write beat is accepted or the last read beat is received.
- Minimum command spacing is len+3 cycles.

## Configuration
- `VTA_MEM_SEQ_STATS_EN`:
  - Defined: adds 32-bit outputs `stat_cmds`, `stat_wr_beats`, `stat_rd_beats`. They reset to 0, increment on each command handshake, `dpi_wr_valid` beat and FIFO push respectively, and wrap modulo 2^32.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Write, addr 0x1000, len 3, beats 0xA0..0xA3 with `wr_valid` held high → `dpi_req_valid` for one cycle with opcode 1, len 3, addr 0x1000; four `dpi_wr_valid` pulses carrying 0xA0..0xA3 in order; `cmd_ready` high again the cycle after the 4th beat is accepted.
- Read, len 7, `rd_ready`=0, depth 4 → `dpi_rd_ready` drops once 3 entries are used. The in-flight beat fills entry 4; `err` stays 0. Raising `rd_ready` drains all 8 beats in order.
- Read, len 0 → exactly one beat is returned; FSM back in IDLE one cycle after `dpi_rd_valid`.
- `dpi_rd_valid` pulsed while IDLE → `err`=1, FIFO unchanged, `err` holds until reset.
- `reset` driven to 0 during beat 2 of a len-5 write → all outputs go to reset values immediately; after release, a new read command completes normally.
- With `VTA_MEM_SEQ_STATS_EN`: write len 3 followed by read len 1 → `stat_cmds`=2, `stat_wr_beats`=4, `stat_rd_beats`=2.

Source files
------------

// File: rtl/vta_mem_req_sequencer_if.sv
// Command, write-stream, read-stream and DPI model signals of vta_mem_req_sequencer.
// The sequencer uses the slave modport; the load/store units and DPI model drive the master side.
interface vta_mem_req_sequencer_if #(
    parameter int unsigned LEN_BITS  = 32,
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned DATA_BITS = 64
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_opcode;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [LEN_BITS-1:0]  cmd_len;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [DATA_BITS-1:0] wr_bits;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [DATA_BITS-1:0] rd_bits;

    logic                 busy;
    logic                 err;

    logic                 dpi_req_valid;
    logic                 dpi_req_opcode;
    logic [LEN_BITS-1:0]  dpi_req_len;
    logic [ADDR_BITS-1:0] dpi_req_addr;
    logic                 dpi_wr_valid;
    logic [DATA_BITS-1:0] dpi_wr_bits;
    logic                 dpi_rd_valid;
    logic [DATA_BITS-1:0] dpi_rd_bits;
    logic                 dpi_rd_ready;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_addr, cmd_len,
        input  wr_valid, wr_bits,
        input  rd_ready,
        input  dpi_rd_valid, dpi_rd_bits,
        output cmd_ready, wr_ready, rd_valid, rd_bits, busy, err,
        output dpi_req_valid, dpi_req_opcode, dpi_req_len, dpi_req_addr,
        output dpi_wr_valid, dpi_wr_bits, dpi_rd_ready
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_addr, cmd_len,
        output wr_valid, wr_bits,
        output rd_ready,
        output dpi_rd_valid, dpi_rd_bits,
        input  cmd_ready, wr_ready, rd_valid, rd_bits, busy, err,
        input  dpi_req_valid, dpi_req_opcode, dpi_req_len, dpi_req_addr,
        input  dpi_wr_valid, dpi_wr_bits, dpi_rd_ready
    );
endinterface

// File: rtl/vta_mem_req_sequencer.sv
// Burst command sequencer in front of the DPI memory model, with a read FIFO sized for the
// model's registered read path. Optional statistics counters under VTA_MEM_SEQ_STATS_EN.
module vta_mem_req_sequencer #(
    parameter int unsigned LEN_BITS      = 32,
    parameter int unsigned ADDR_BITS     = 64,
    parameter int unsigned DATA_BITS     = 64,
    parameter int unsigned RD_FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    vta_mem_req_sequencer_if.slave        bus
`ifdef VTA_MEM_SEQ_STATS_EN
    ,
    output logic [31:0]                   stat_cmds,
    output logic [31:0]                   stat_wr_beats,
    output logic [31:0]                   stat_rd_beats
`endif
);

    localparam int unsigned PtrBits = $clog2(RD_FIFO_DEPTH);
    localparam int unsigned PtrW    = PtrBits + 1;
    // Keep one free slot for the beat already launched by the model's registered output.
    localparam logic [PtrW-1:0] UsedMaxForReady = PtrW'(RD_FIFO_DEPTH - 2);

    typedef enum logic [1:0] {StIdle, StReq, StWrite, StRead} state_e;

    state_e               state_q, state_d;
    logic                 opcode_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  len_q;
    logic [LEN_BITS-1:0]  cnt_q, cnt_d;
    logic                 dpi_wr_valid_q;
    logic [DATA_BITS-1:0] dpi_wr_bits_q;
    logic                 err_q;

    logic [DATA_BITS-1:0] fifo_mem [RD_FIFO_DEPTH];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [PtrW-1:0]      fifo_used;
    logic                 fifo_empty, fifo_full;

    logic cmd_ready_int, cmd_fire, wr_fire, req_active;
    logic push, pop, drop;

    assign cmd_ready_int = (state_q == StIdle) & reset;
    assign cmd_fire      = bus.cmd_valid & cmd_ready_int;
    assign wr_fire       = bus.wr_valid & (state_q == StWrite);
    assign req_active    = (state_q == StReq);

    assign fifo_used  = wptr_q - rptr_q;
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PtrBits] != rptr_q[PtrBits]) &&
                        (wptr_q[PtrBits-1:0] == rptr_q[PtrBits-1:0]);

    // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
    assign pop  = bus.rd_ready & ~fifo_empty;
    assign push = bus.dpi_rd_valid & (state_q == StRead) & (~fifo_full | pop);
    assign drop = bus.dpi_rd_valid & ~push;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                state_d = opcode_q ? StWrite : StRead;
            end
            StWrite: begin
                if (wr_fire) begin
                    if (cnt_q == len_q) state_d = StIdle;
                    else                cnt_d   = cnt_q + LEN_BITS'(1);
                end
            end
            StRead: begin
                if (push) begin
                    if (cnt_q == len_q) state_d = StIdle;
                    else                cnt_d   = cnt_q + LEN_BITS'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            opcode_q       <= 1'b0;
            addr_q         <= '0;
            len_q          <= '0;
            dpi_wr_valid_q <= 1'b0;
            dpi_wr_bits_q  <= '0;
            err_q          <= 1'b0;
            wptr_q         <= '0;
            rptr_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dpi_wr_valid_q <= wr_fire;
            dpi_wr_bits_q  <= wr_fire ? bus.wr_bits : '0;
            if (cmd_fire) begin
                opcode_q <= bus.cmd_opcode;
                addr_q   <= bus.cmd_addr;
                len_q    <= bus.cmd_len;
            end
            if (drop) err_q  <= 1'b1;
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wptr_q[PtrBits-1:0]] <= bus.dpi_rd_bits;
    end

    assign bus.cmd_ready      = cmd_ready_int;
    assign bus.wr_ready       = (state_q == StWrite);
    assign bus.rd_valid       = ~fifo_empty;
    assign bus.rd_bits        = fifo_mem[rptr_q[PtrBits-1:0]];
    assign bus.busy           = (state_q != StIdle) | ~fifo_empty;
    assign bus.err            = err_q;
    assign bus.dpi_req_valid  = req_active;
    assign bus.dpi_req_opcode = req_active & opcode_q;
    assign bus.dpi_req_len    = {LEN_BITS{req_active}} & len_q;
    assign bus.dpi_req_addr   = {ADDR_BITS{req_active}} & addr_q;
    assign bus.dpi_wr_valid   = dpi_wr_valid_q;
    assign bus.dpi_wr_bits    = dpi_wr_bits_q;
    assign bus.dpi_rd_ready   = (state_q == StRead) && (fifo_used <= UsedMaxForReady);

`ifdef VTA_MEM_SEQ_STATS_EN
    logic [31:0] stat_cmds_q, stat_wr_beats_q, stat_rd_beats_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_cmds_q     <= '0;
            stat_wr_beats_q <= '0;
            stat_rd_beats_q <= '0;
        end else begin
            if (cmd_fire)       stat_cmds_q     <= stat_cmds_q + 32'd1;
            if (dpi_wr_valid_q) stat_wr_beats_q <= stat_wr_beats_q + 32'd1;
            if (push)           stat_rd_beats_q <= stat_rd_beats_q + 32'd1;
        end
    end

    assign stat_cmds     = stat_cmds_q;
    assign stat_wr_beats = stat_wr_beats_q;
    assign stat_rd_beats = stat_rd_beats_q;
`endif

endmodule

// File: tb/tb_vta_mem_req_sequencer.sv
// Randomized bench for vta_mem_req_sequencer with a queue-based model of the read FIFO and the
// DPI model's registered read path; statistics checked when VTA_MEM_SEQ_STATS_EN is defined.
module tb_vta_mem_req_sequencer;

    localparam int unsigned LEN_BITS  = 32;
    localparam int unsigned ADDR_BITS = 64;
    localparam int unsigned DATA_BITS = 64;
    localparam int unsigned DEPTH     = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    int exp_cmds = 0;
    int exp_wr   = 0;
    int exp_rd   = 0;

    always #5 clock = ~clock;

    vta_mem_req_sequencer_if #(
        .LEN_BITS (LEN_BITS),
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(DATA_BITS)
    ) bus ();

`ifdef VTA_MEM_SEQ_STATS_EN
    logic [31:0] stat_cmds, stat_wr_beats, stat_rd_beats;
`endif

    vta_mem_req_sequencer #(
        .LEN_BITS     (LEN_BITS),
        .ADDR_BITS    (ADDR_BITS),
        .DATA_BITS    (DATA_BITS),
        .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
`ifdef VTA_MEM_SEQ_STATS_EN
        ,
        .stat_cmds    (stat_cmds),
        .stat_wr_beats(stat_wr_beats),
        .stat_rd_beats(stat_rd_beats)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed no completion expected completion within cycle budget", tag);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cmd_valid    = 1'b0;
        bus.cmd_opcode   = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_len      = '0;
        bus.wr_valid     = 1'b0;
        bus.wr_bits      = '0;
        bus.rd_ready     = 1'b0;
        bus.dpi_rd_valid = 1'b0;
        bus.dpi_rd_bits  = '0;
    endtask

    task automatic check_reset_values(input string p);
        chk({p, "_cmd_ready"}, bus.cmd_ready, 0);
        chk({p, "_wr_ready"}, bus.wr_ready, 0);
        chk({p, "_rd_valid"}, bus.rd_valid, 0);
        chk({p, "_busy"}, bus.busy, 0);
        chk({p, "_err"}, bus.err, 0);
        chk({p, "_dpi_req_valid"}, bus.dpi_req_valid, 0);
        chk({p, "_dpi_req_opcode"}, bus.dpi_req_opcode, 0);
        chk({p, "_dpi_req_len"}, bus.dpi_req_len, 0);
        chk({p, "_dpi_req_addr"}, bus.dpi_req_addr, 0);
        chk({p, "_dpi_wr_valid"}, bus.dpi_wr_valid, 0);
        chk({p, "_dpi_wr_bits"}, bus.dpi_wr_bits, 0);
        chk({p, "_dpi_rd_ready"}, bus.dpi_rd_ready, 0);
`ifdef VTA_MEM_SEQ_STATS_EN
        chk({p, "_stat_cmds"}, stat_cmds, 0);
        chk({p, "_stat_wr"}, stat_wr_beats, 0);
        chk({p, "_stat_rd"}, stat_rd_beats, 0);
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        check_reset_values("rst");
        reset = 1'b1;
        exp_cmds = 0;
        exp_wr   = 0;
        exp_rd   = 0;
        tick();
    endtask

    // Issues a command and checks the single request cycle that follows it.
    task automatic issue_cmd(input bit op, input logic [63:0] addr, input int len);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_addr   = addr;
        bus.cmd_len    = LEN_BITS'(len);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        tick();
        exp_cmds++;
        bus.cmd_valid = 1'b0;
        chk("req_valid", bus.dpi_req_valid, 1);
        chk("req_opcode", bus.dpi_req_opcode, op);
        chk("req_len", bus.dpi_req_len, 64'(len));
        chk("req_addr", bus.dpi_req_addr, addr);
        chk("req_cmd_ready", bus.cmd_ready, 0);
        chk("req_wr_ready", bus.wr_ready, 0);
        chk("req_dpi_rd_ready", bus.dpi_rd_ready, 0);
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input logic [63:0] base,
                            input bit hold);
        int          beat = 0;
        int          cyc = 0;
        bit          acc;
        bit          acc_prev = 1'b0;
        logic [63:0] last_bits = '0;
        issue_cmd(1'b1, addr, len);
        tick();
        chk("req_one_shot", bus.dpi_req_valid, 0);
        while (beat <= len && cyc < 1000) begin
            chk("dpi_wr_valid", bus.dpi_wr_valid, acc_prev);
            if (acc_prev) chk("dpi_wr_bits", bus.dpi_wr_bits, last_bits);
            chk("wr_ready", bus.wr_ready, 1);
            chk("wr_busy", bus.busy, 1);
            bus.wr_valid = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.wr_bits  = base + 64'(beat);
            acc = bus.wr_valid;
            if (acc) begin
                last_bits = base + 64'(beat);
                beat++;
                exp_wr++;
            end
            acc_prev = acc;
            cyc++;
            tick();
        end
        if (beat <= len) timeout("wr_burst");
        bus.wr_valid = 1'b0;
        chk("dpi_wr_valid_last", bus.dpi_wr_valid, acc_prev);
        chk("dpi_wr_bits_last", bus.dpi_wr_bits, last_bits);
        chk("wr_cmd_ready_after_last", bus.cmd_ready, 1);
        chk("wr_ready_after_last", bus.wr_ready, 0);
        tick();
        chk("dpi_wr_valid_idle", bus.dpi_wr_valid, 0);
    endtask

    // The DPI model may present a beat only in the cycle after it saw dpi_rd_ready high.
    task automatic do_read(input logic [63:0] addr, input int len, input logic [63:0] base,
                           input int hold, input bit gapless, input bit rand_rd);
        logic [63:0] q[$];
        int  sent = 0;
        int  cyc = 0;
        bit  in_read = 1'b1;
        bit  r_prev = 1'b0;
        bit  exp_ready, pop, push, last;
        issue_cmd(1'b0, addr, len);
        tick();
        while ((in_read || q.size() != 0) && cyc < 2000) begin
            chk("rd_valid", bus.rd_valid, q.size() != 0);
            if (q.size() != 0) chk("rd_bits", bus.rd_bits, q[0]);
            exp_ready = in_read && (q.size() <= DEPTH - 2);
            chk("dpi_rd_ready", bus.dpi_rd_ready, exp_ready);
            chk("rd_busy", bus.busy, in_read || q.size() != 0);
            chk("rd_err", bus.err, 0);
            bus.dpi_rd_valid = r_prev && (sent <= len) && (gapless || $urandom_range(0, 3) != 0);
            bus.dpi_rd_bits  = base + 64'(sent);
            bus.rd_ready     = (cyc < hold) ? 1'b0 : (rand_rd ? ($urandom_range(0, 1) == 1) : 1'b1);
            pop  = (q.size() != 0) && bus.rd_ready;
            push = bus.dpi_rd_valid;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(base + 64'(sent));
                sent++;
                exp_rd++;
            end
            r_prev = exp_ready;
            last = push && (sent == len + 1);
            if (last) in_read = 1'b0;
            cyc++;
            tick();
            if (last) chk("rd_cmd_ready_after_last", bus.cmd_ready, 1);
        end
        if (in_read || q.size() != 0) timeout("rd_burst");
        bus.dpi_rd_valid = 1'b0;
        bus.rd_ready     = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("por");
        reset = 1'b1;
        tick();
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        do_write(64'h1000, 3, 64'hA0, 1'b1);

        // Stalled consumer: the FIFO must fill to all four entries without an error.
        do_read(64'h2000, 7, 64'hB0, 10, 1'b1, 1'b0);

        do_read(64'h3000, 0, 64'hC0, 0, 1'b1, 1'b0);

        // Stray read beat while idle.
        chk("pre_err", bus.err, 0);
        bus.dpi_rd_valid = 1'b1;
        bus.dpi_rd_bits  = 64'hDEAD;
        tick();
        bus.dpi_rd_valid = 1'b0;
        chk("stray_err", bus.err, 1);
        chk("stray_rd_valid", bus.rd_valid, 0);
        chk("stray_busy", bus.busy, 0);
        repeat (3) tick();
        chk("err_sticky", bus.err, 1);

        // Reset while beat 2 of a len-5 write is on the bus.
        issue_cmd(1'b1, 64'h4000, 5);
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_bits  = 64'hE0;
        tick();
        bus.wr_bits  = 64'hE1;
        tick();
        bus.wr_bits  = 64'hE2;
        chk("midrst_wr_valid_before", bus.dpi_wr_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        clear_inputs();
        repeat (2) tick();
        check_reset_values("midrst_hold");
        reset = 1'b1;
        exp_cmds = 0;
        exp_wr   = 0;
        exp_rd   = 0;
        tick();
        do_read(64'h5000, 4, 64'hF0, 0, 1'b0, 1'b1);

        do_reset();
        do_write(64'h6000, 3, 64'h10, 1'b1);
        do_read(64'h7000, 1, 64'h20, 0, 1'b1, 1'b0);
`ifdef VTA_MEM_SEQ_STATS_EN
        chk("stat_cmds_pair", stat_cmds, 32'(exp_cmds));
        chk("stat_wr_pair", stat_wr_beats, 32'(exp_wr));
        chk("stat_rd_pair", stat_rd_beats, 32'(exp_rd));
`endif

        for (int i = 0; i < 16; i++) begin
            bit          op;
            int          len;
            logic [63:0] addr, base;
            op   = ($urandom_range(0, 1) == 1);
            len  = int'($urandom_range(0, 9));
            addr = {$urandom(), $urandom()};
            base = {$urandom(), $urandom()};
            if (op) do_write(addr, len, base, ($urandom_range(0, 1) == 1));
            else    do_read(addr, len, base, int'($urandom_range(0, 6)),
                            ($urandom_range(0, 1) == 1), 1'b1);
        end

`ifdef VTA_MEM_SEQ_STATS_EN
        chk("stat_cmds_end", stat_cmds, 32'(exp_cmds));
        chk("stat_wr_end", stat_wr_beats, 32'(exp_wr));
        chk("stat_rd_end", stat_rd_beats, 32'(exp_rd));
`endif
        chk("end_busy", bus.busy, 0);
        chk("end_err", bus.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
